sar_search: RTL and testbench

Successive-approximation search controller; the driving end of the magnitude-comparator interface. It presents a trial code to an external comparator and reads back the greater/lesser/equal flags. From those flags it resolves the comparator's hidden target one bit per cycle, MSB first. It sits between a control FSM, which issues `start` and collects `result`, and a combinational comparator whose one operand is `trial`.

---
 rtl/sar_search.sv | 135 +++++++++++++
 tb/tb_sar_search.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller driving a magnitude comparator, MSB first.
// Optional SAR_EARLY_EXIT_EN: finish the search on the first valid equal flag.
module sar_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             greater,
    input  logic             lesser,
    input  logic             equal,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int unsigned IW = $clog2(WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] p, p_n;
    logic [WIDTH-1:0] trial_n, result_n;
    logic             busy_n, done_n, exact_n, err_n;

    logic [WIDTH-1:0] p_step;
    logic             flags_valid;
    logic             early_stop;
    logic             finish;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            p      <= '0;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            exact  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            p      <= p_n;
            trial  <= trial_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            exact  <= exact_n;
            err    <= err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        p_n         = p;
        trial_n     = trial;
        result_n    = result;
        busy_n      = busy;
        done_n      = 1'b0;
        exact_n     = exact;
        err_n       = err;
        finish      = 1'b0;
        flags_valid = ({greater, lesser, equal} == 3'b100) ||
                      ({greater, lesser, equal} == 3'b010) ||
                      ({greater, lesser, equal} == 3'b001);
        // A lesser or equal answer keeps the trial bit, so the new partial code is the trial itself
        p_step      = greater ? p : trial;
        early_stop  = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
        early_stop  = equal;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEARCH;
                    idx_n   = IW'(WIDTH - 1);
                    p_n     = '0;
                    trial_n = WIDTH'(1) << (WIDTH - 1);
                    exact_n = 1'b0;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            SEARCH: begin
                if (!flags_valid) begin
                    err_n    = 1'b1;
                    result_n = p;
                    trial_n  = p;
                    finish   = 1'b1;
                end else if (early_stop) begin
                    result_n = trial;
                    trial_n  = trial;
                    exact_n  = 1'b1;
                    finish   = 1'b1;
                end else if (idx == '0) begin
                    result_n = p_step;
                    trial_n  = p_step;
                    exact_n  = exact | equal;
                    finish   = 1'b1;
                end else begin
                    idx_n    = idx - IW'(1);
                    p_n      = p_step;
                    trial_n  = p_step | (WIDTH'(1) << (idx - IW'(1)));
                    exact_n  = exact | equal;
                end
                if (finish) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: comparator model plus a search reference model.
module tb_sar_search;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         force_none = 1'b0;
    logic [W-1:0] target = '0;
    logic         greater, lesser, equal;
    logic [W-1:0] trial, result;
    logic         busy, done, exact, err;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_tr [W];
    int           exp_n;
    logic [W-1:0] exp_res;
    logic         exp_exact, exp_err;
    bit           early;

    sar_search #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .greater(greater), .lesser(lesser), .equal(equal),
        .trial(trial), .busy(busy), .done(done),
        .result(result), .exact(exact), .err(err)
    );

    always #5 clk = ~clk;

    // Combinational comparator; force_none drops every flag to fake a broken comparator
    assign greater = !force_none && (trial > target);
    assign lesser  = !force_none && (trial < target);
    assign equal   = !force_none && (trial == target);

    // Binary search by plain arithmetic: keep a trial bit whenever trial <= target
    task automatic model(input logic [W-1:0] tgt, input int bad_step);
        logic [W-1:0] pp, t;
        bit stop;
        pp = '0; exp_n = 0; exp_exact = 1'b0; exp_err = 1'b0; exp_res = '0; stop = 0;
        for (int i = W - 1; i >= 0 && !stop; i--) begin
            t = pp | W'(1 << i);
            exp_tr[exp_n] = t;
            exp_n++;
            if (exp_n == bad_step) begin
                exp_err = 1'b1;
                exp_res = pp;
                stop = 1;
            end else begin
                if (t == tgt) begin
                    exp_exact = 1'b1;
                    if (early) begin
                        exp_res = t;
                        stop = 1;
                    end
                end
                if (t <= tgt) pp = t;
            end
        end
        if (!stop) exp_res = pp;
    endtask

    task automatic run_search(input logic [W-1:0] tgt, input int bad_step, input bit poke,
                              input string tag);
        model(tgt, bad_step);
        target = tgt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < exp_n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            tests++;
            if (trial !== exp_tr[k] || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s step%0d tgt=%0d: trial=%0d busy=%b done=%b, want trial=%0d busy=1 done=0",
                         tag, k, tgt, trial, busy, done, exp_tr[k]);
            end
            if (k == 0) begin
                tests++;
                if (exact !== 1'b0 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL %s clear_on_start: exact=%b err=%b, want 0 0", tag, exact, err);
                end
            end
            if (k + 1 == bad_step) force_none = 1'b1;
            if (poke && k == 1) start = 1'b1;
        end
        @(posedge clk);
        #1;
        force_none = 1'b0;
        start = poke;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res || exact !== exp_exact ||
            err !== exp_err || trial !== exp_res) begin
            fails++;
            $display("FAIL %s end tgt=%0d: done=%b busy=%b result=%0d exact=%b err=%b trial=%0d, want 1 0 %0d %b %b %0d",
                     tag, tgt, done, busy, result, exact, err, trial, exp_res, exp_exact, exp_err, exp_res);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || trial !== exp_res ||
            exact !== exp_exact || err !== exp_err) begin
            fails++;
            $display("FAIL %s hold: done=%b busy=%b result=%0d trial=%0d exact=%b err=%b, want 0 0 %0d %0d %b %b",
                     tag, done, busy, result, trial, exact, err, exp_res, exp_res, exp_exact, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (trial !== '0 || result !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            exact !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset: trial=%0d result=%0d busy=%b done=%b exact=%b err=%b, want all 0",
                     trial, result, busy, done, exact, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_plan_cases();
        run_search(4'd11, 0, 0, "tgt11");
        run_search(4'd12, 0, 0, "tgt12");
        run_search(4'd0, 0, 0, "tgt0");
        run_search(4'd15, 0, 0, "tgt15");
        run_search(4'd8, 0, 0, "tgt8");
    endtask

    task automatic test_invalid_flags();
        run_search(4'd11, 2, 0, "invalid_e2");
        run_search(4'd5, 0, 0, "after_err");
        run_search(4'd6, 1, 0, "invalid_e1");
        run_search(4'd7, 4, 0, "invalid_e4");
    endtask

    task automatic test_start_ignored();
        run_search(4'd9, 0, 1, "poke9");
        run_search(4'd3, 0, 1, "poke3");
    endtask

    task automatic test_async_reset();
        target = 4'd9;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (trial !== '0 || result !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            exact !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: trial=%0d result=%0d busy=%b done=%b exact=%b err=%b, want all 0",
                     trial, result, busy, done, exact, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_search(4'd9, 0, 0, "after_rst");
    endtask

    task automatic test_random();
        logic [W-1:0] tgt;
        for (int n = 0; n < 24; n++) begin
            tgt = W'($urandom_range(0, (1 << W) - 1));
            if (n % 6 == 5) run_search(tgt, int'($urandom_range(1, W)), 0, "rand_bad");
            else            run_search(tgt, 0, n % 4 == 3, "rand");
        end
    endtask

    initial begin
`ifdef SAR_EARLY_EXIT_EN
        early = 1;
`else
        early = 0;
`endif
        test_reset();
        test_plan_cases();
        test_invalid_flags();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
